ps2_key_sequencer: RTL and testbench

Sequencing controller for the PS/2 scancode-to-ASCII translator. It consumes raw scancode bytes from the PS/2 receiver and tracks make, break (0xF0) and extended (0xE0) prefixes plus left and right shift state. For each printable make code it presents the code and shift level to the translator, samples the ASCII result one cycle later, and queues non-zero results in a small FWFT FIFO with a valid/ready handshake toward the consumer (UART, text display).

---
 rtl/ps2_key_sequencer.sv | 172 +++++++++++++++++
 tb/tb_ps2_key_sequencer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_sequencer.sv
// ps2_key_sequencer: tracks PS/2 make/break/extended prefixes and shift state,
// drives the scancode translator, and queues non-zero ASCII results in a
// first-word-fall-through FIFO with a valid/ready handshake.
// Optional build macro PS2_REPEAT_SUPPRESS_EN: drop repeated make codes
// (typematic repeat) until the key's break code is seen.
module ps2_key_sequencer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] code_in,
  input  logic       code_valid,
  output logic [7:0] xlat_char,
  output logic       xlat_shift,
  input  logic [7:0] xlat_ascii,
  output logic [7:0] ascii_out,
  output logic       ascii_valid,
  input  logic       ascii_ready,
  output logic       err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FullCount = (AW+1)'(DEPTH);

  localparam logic [7:0] CodeBreak  = 8'hF0;
  localparam logic [7:0] CodeExt    = 8'hE0;
  localparam logic [7:0] CodeLShift = 8'h12;
  localparam logic [7:0] CodeRShift = 8'h59;

  typedef enum logic [2:0] {
    StIdle,
    StBrk,
    StExt,
    StExtBrk,
    StLookup
  } state_e;

  state_e      state_q;
  logic        lshift_q;
  logic        rshift_q;
  logic [7:0]  xlat_char_q;
  logic        xlat_shift_q;
  logic        err_q;

  logic [7:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0] count_q;
  logic [AW:0] count_d;

  logic push_req;
  logic push_ok;
  logic pop;
  logic full;

`ifdef PS2_REPEAT_SUPPRESS_EN
  logic [7:0] last_make_q;
`endif

  assign push_req = (state_q == StLookup) && (xlat_ascii != 8'h00);
  assign full     = (count_q == FullCount);
  assign pop      = ascii_valid && ascii_ready;
  // A push into a full FIFO still lands if the head leaves in the same cycle.
  assign push_ok  = push_req && (!full || pop);

  // Prefix/shift tracking FSM with registered translator inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      lshift_q     <= 1'b0;
      rshift_q     <= 1'b0;
      xlat_char_q  <= 8'h00;
      xlat_shift_q <= 1'b0;
`ifdef PS2_REPEAT_SUPPRESS_EN
      last_make_q  <= 8'h00;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (code_valid) begin
            if (code_in == CodeBreak) begin
              state_q <= StBrk;
            end else if (code_in == CodeExt) begin
              state_q <= StExt;
            end else if (code_in == CodeLShift) begin
              lshift_q <= 1'b1;
            end else if (code_in == CodeRShift) begin
              rshift_q <= 1'b1;
`ifdef PS2_REPEAT_SUPPRESS_EN
            end else if (code_in != last_make_q) begin
              last_make_q  <= code_in;
              xlat_char_q  <= code_in;
              xlat_shift_q <= lshift_q | rshift_q;
              state_q      <= StLookup;
            end
`else
            end else begin
              xlat_char_q  <= code_in;
              xlat_shift_q <= lshift_q | rshift_q;
              state_q      <= StLookup;
            end
`endif
          end
        end
        StBrk: begin
          if (code_valid) begin
            if (code_in == CodeLShift) lshift_q <= 1'b0;
            if (code_in == CodeRShift) rshift_q <= 1'b0;
`ifdef PS2_REPEAT_SUPPRESS_EN
            if (code_in == last_make_q) last_make_q <= 8'h00;
`endif
            state_q <= StIdle;
          end
        end
        StExt: begin
          if (code_valid) begin
            state_q <= (code_in == CodeBreak) ? StExtBrk : StIdle;
          end
        end
        StExtBrk: begin
          if (code_valid) state_q <= StIdle;
        end
        StLookup: state_q <= StIdle;
        default:  state_q <= StIdle;
      endcase
    end
  end

  // Next FIFO occupancy.
  always_comb begin
    count_d = count_q;
    if (push_ok && !pop) begin
      count_d = count_q + (AW+1)'(1);
    end else if (!push_ok && pop) begin
      count_d = count_q - (AW+1)'(1);
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  // FIFO storage; contents need no reset since the count gates visibility.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) mem_q[wr_ptr_q] <= xlat_ascii;
  end

  // Sticky error: byte arriving during lookup, or push dropped on a full FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if ((state_q == StLookup && code_valid) || (push_req && full && !pop)) begin
      err_q <= 1'b1;
    end
  end

  assign xlat_char   = xlat_char_q;
  assign xlat_shift  = xlat_shift_q;
  assign ascii_valid = (count_q != '0);
  assign ascii_out   = ascii_valid ? mem_q[rd_ptr_q] : 8'h00;
  assign err         = err_q;

endmodule

// File: tb/tb_ps2_key_sequencer.sv
// Self-checking bench for ps2_key_sequencer with a behavioural translator model.
module tb_ps2_key_sequencer;

  localparam int unsigned DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] code_in;
  logic       code_valid;
  logic [7:0] xlat_char;
  logic       xlat_shift;
  logic [7:0] xlat_ascii;
  logic [7:0] ascii_out;
  logic       ascii_valid;
  logic       ascii_ready;
  logic       err;

  int ncmp  = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  ps2_key_sequencer #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .code_in     (code_in),
    .code_valid  (code_valid),
    .xlat_char   (xlat_char),
    .xlat_shift  (xlat_shift),
    .xlat_ascii  (xlat_ascii),
    .ascii_out   (ascii_out),
    .ascii_valid (ascii_valid),
    .ascii_ready (ascii_ready),
    .err         (err)
  );

  // Translator model: digits and 0x45 map regardless of shift; others unmapped.
  function automatic logic [7:0] xlat(input logic [7:0] c, input logic s);
    logic [7:0] r;
    r = 8'h00;
    case (c)
      8'h16: r = 8'h31;
      8'h1E: r = 8'h32;
      8'h26: r = 8'h33;
      8'h25: r = 8'h34;
      8'h2E: r = 8'h35;
      8'h36: r = 8'h36;
      8'h45: r = s ? 8'h30 : 8'h30;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  always_comb xlat_ascii = xlat(xlat_char, xlat_shift);

  typedef struct {
    logic [7:0] code;
    logic [7:0] exp_char;
    logic       exp_shift;
    logic [7:0] exp_ascii;
  } vec_t;

  vec_t vecs [20];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic strobe(input logic [7:0] c);
    code_in    = c;
    code_valid = 1'b1;
    tick();
    code_valid = 1'b0;
    code_in    = 8'h00;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  logic [7:0] exp_q [$];
  int         got;
  int         exp_cnt;

  initial begin
    rst         = 1'b1;
    code_in     = 8'h00;
    code_valid  = 1'b0;
    ascii_ready = 1'b0;

    // Reset state
    do_reset();
    chk("rst_char",  xlat_char,   8'h00);
    chk("rst_shift", xlat_shift,  1'b0);
    chk("rst_valid", ascii_valid, 1'b0);
    chk("rst_out",   ascii_out,   8'h00);
    chk("rst_err",   err,         1'b0);

    // Basic latency and handshake
    tick();
    strobe(8'h16);
    chk("lat_char",   xlat_char,   8'h16);
    chk("lat_shift",  xlat_shift,  1'b0);
    chk("lat_valid1", ascii_valid, 1'b0);
    tick();
    chk("lat_valid2", ascii_valid, 1'b1);
    chk("lat_out",    ascii_out,   8'h31);
    tick();
    chk("lat_hold",   ascii_out,   8'h31);
    ascii_ready = 1'b1;
    tick();
    chk("lat_pop",    ascii_valid, 1'b0);

    // Table-driven single-code vectors, ready held high
    vecs[0]  = '{8'h16, 8'h16, 1'b0, 8'h31};
    vecs[1]  = '{8'hF0, 8'h16, 1'b0, 8'h00};
    vecs[2]  = '{8'h16, 8'h16, 1'b0, 8'h00};
    vecs[3]  = '{8'h12, 8'h16, 1'b0, 8'h00};
    vecs[4]  = '{8'h45, 8'h45, 1'b1, 8'h30};
    vecs[5]  = '{8'hF0, 8'h45, 1'b1, 8'h00};
    vecs[6]  = '{8'h45, 8'h45, 1'b1, 8'h00};
    vecs[7]  = '{8'hF0, 8'h45, 1'b1, 8'h00};
    vecs[8]  = '{8'h12, 8'h45, 1'b1, 8'h00};
    vecs[9]  = '{8'h45, 8'h45, 1'b0, 8'h30};
    vecs[10] = '{8'hE0, 8'h45, 1'b0, 8'h00};
    vecs[11] = '{8'h16, 8'h45, 1'b0, 8'h00};
    vecs[12] = '{8'hE0, 8'h45, 1'b0, 8'h00};
    vecs[13] = '{8'hF0, 8'h45, 1'b0, 8'h00};
    vecs[14] = '{8'h16, 8'h45, 1'b0, 8'h00};
    vecs[15] = '{8'h59, 8'h45, 1'b0, 8'h00};
    vecs[16] = '{8'h1E, 8'h1E, 1'b1, 8'h32};
    vecs[17] = '{8'hF0, 8'h1E, 1'b1, 8'h00};
    vecs[18] = '{8'h59, 8'h1E, 1'b1, 8'h00};
    vecs[19] = '{8'h1C, 8'h1C, 1'b0, 8'h00};

    do_reset();
    ascii_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      strobe(vecs[i].code);
      chk($sformatf("v%0d_char", i),  xlat_char,  vecs[i].exp_char);
      chk($sformatf("v%0d_shift", i), xlat_shift, vecs[i].exp_shift);
      tick();
      chk($sformatf("v%0d_valid", i), ascii_valid, vecs[i].exp_ascii != 8'h00);
      chk($sformatf("v%0d_out", i),   ascii_out,   vecs[i].exp_ascii);
      tick();
      chk($sformatf("v%0d_drain", i), ascii_valid, 1'b0);
      chk($sformatf("v%0d_err", i),   err,         1'b0);
    end
    ascii_ready = 1'b0;

    // Fill, push+pop while full, then overflow
    do_reset();
    exp_q = '{};
    foreach (vecs[i]) begin end
    strobe(8'h16); tick(); tick();
    strobe(8'h1E); tick(); tick();
    strobe(8'h26); tick(); tick();
    strobe(8'h25); tick(); tick();
    chk("full_err0", err,       1'b0);
    chk("full_head", ascii_out, 8'h31);
    strobe(8'h2E);
    ascii_ready = 1'b1;
    tick();
    ascii_ready = 1'b0;
    chk("pp_err",   err,         1'b0);
    chk("pp_valid", ascii_valid, 1'b1);
    chk("pp_head",  ascii_out,   8'h32);
    strobe(8'h36); tick(); tick();
    chk("ovf_err",  err,         1'b1);
    chk("ovf_head", ascii_out,   8'h32);
    exp_q = '{8'h32, 8'h33, 8'h34, 8'h35};
    ascii_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain%0d_valid", i), ascii_valid, 1'b1);
      chk($sformatf("drain%0d_out", i),   ascii_out,   exp_q[i]);
      tick();
    end
    chk("drain_empty", ascii_valid, 1'b0);
    chk("drain_err",   err,         1'b1);
    ascii_ready = 1'b0;

    // Typematic repeat behaviour
    do_reset();
    strobe(8'h16); tick(); tick();
    strobe(8'h16); tick(); tick();
    strobe(8'h16); tick(); tick();
    strobe(8'hF0); tick(); tick();
    strobe(8'h16); tick(); tick();
    strobe(8'h16); tick(); tick();
`ifdef PS2_REPEAT_SUPPRESS_EN
    exp_cnt = 2;
`else
    exp_cnt = 4;
`endif
    got = 0;
    ascii_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (ascii_valid) begin
        got++;
        chk($sformatf("rep%0d_out", i), ascii_out, 8'h31);
      end
      tick();
    end
    ascii_ready = 1'b0;
    chk("rep_count", got, exp_cnt);
    chk("rep_err",   err, 1'b0);

    // Byte arriving during LOOKUP is dropped and flagged
    do_reset();
    strobe(8'h16);
    strobe(8'h1E);
    tick();
    chk("lk_err",   err,         1'b1);
    chk("lk_valid", ascii_valid, 1'b1);
    chk("lk_out",   ascii_out,   8'h31);
    ascii_ready = 1'b1;
    tick();
    chk("lk_one",   ascii_valid, 1'b0);
    ascii_ready = 1'b0;

    // Reset mid-operation: shift held and break prefix pending
    strobe(8'h16); tick();
    strobe(8'h12); tick();
    strobe(8'hF0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_valid", ascii_valid, 1'b0);
    chk("mrst_err",   err,         1'b0);
    chk("mrst_char",  xlat_char,   8'h00);
    strobe(8'h16);
    chk("mrst_lchar",  xlat_char,  8'h16);
    chk("mrst_lshift", xlat_shift, 1'b0);
    tick();
    chk("mrst_push",  ascii_out,   8'h31);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
